// File: rtl/axist_bringup_pkg.sv
// Shared definitions for the AXI-ST-over-AIB bring-up sequencer.
// Register map, FSM states, result codes and small helpers.
package axist_bringup_pkg;

  localparam logic [31:0] DELAY_X_ADDR = 32'h5000_2000;
  localparam logic [31:0] DELAY_Y_ADDR = 32'h5000_2004;
  localparam logic [31:0] DELAY_Z_ADDR = 32'h5000_2008;
  localparam logic [31:0] AXI_CTRL     = 32'h5000_3000;
  localparam logic [31:0] TX_PKT_CTRL  = 32'h5000_1000;
  localparam logic [31:0] RX_CKR_STS   = 32'h5000_1004;
  localparam logic [31:0] LINKUP_STS   = 32'h5000_1008;
  localparam logic [31:0] DOUT_FIRST   = 32'h5000_4000;
  localparam logic [31:0] DOUT_LAST    = 32'h5000_4100;
  localparam logic [31:0] DIN_FIRST    = 32'h5000_4200;
  localparam logic [31:0] DIN_LAST     = 32'h5000_4300;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_X,
    S_CFG_Y,
    S_CFG_Z,
    S_RST_ON,
    S_RST_WAIT,
    S_RST_OFF,
    S_LINK_POLL,
    S_PKT_GO,
    S_CKR_POLL,
    S_CAPTURE,
    S_GRADE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_PASS    = 2'd0,
    RES_DATA    = 2'd1,
    RES_ALIGN   = 2'd2,
    RES_TIMEOUT = 2'd3
  } result_e;

  // Capture slot order: dout_first, din_first, dout_last, din_last.
  // Even index reads the low word, odd index the high word.
  function automatic logic [31:0] cap_addr(input logic [2:0] idx);
    logic [31:0] base;
    unique case (idx[2:1])
      2'd0: base = DOUT_FIRST;
      2'd1: base = DIN_FIRST;
      2'd2: base = DOUT_LAST;
      2'd3: base = DIN_LAST;
    endcase
    return base | {29'd0, idx[0], 2'b00};
  endfunction

  // m = {sts[3], sts[1:0]} from the checker status word.
  function automatic result_e grade(input logic [2:0] m);
    if (m == 3'b111)
      return RES_PASS;
    else if (m == 3'b110)
      return RES_DATA;
    else if (!m[2])
      return RES_ALIGN;
    return RES_DATA;
  endfunction

endpackage

// File: rtl/axist_avmm_mst_if.sv
// Single-outstanding AVMM master.
// Latches one command, holds the request until the slave completes it.
module axist_avmm_mst_if
  import axist_bringup_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic        cmd_rd_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        cmd_done_o,
  output logic [31:0] cmd_rdata_o,
  output logic [31:0] avmm_addr_o,
  output logic [31:0] avmm_wdata_o,
  output logic        avmm_wren_o,
  output logic        avmm_rden_o,
  input  logic [31:0] avmm_rdata_i,
  input  logic        avmm_rdvalid_i,
  input  logic        avmm_waitreq_i
);

  logic        wren_q, wren_d;
  logic        rden_q, rden_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = wren_q & ~avmm_waitreq_i;
  assign rd_ok = rden_q & avmm_rdvalid_i & ~avmm_waitreq_i;

  // Drop the request after completion; accept a new command only when idle.
  always_comb begin
    wren_d  = wren_q;
    rden_d  = rden_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (wr_ok)
      wren_d = 1'b0;
    if (rd_ok)
      rden_d = 1'b0;
    if (cmd_valid_i && !wren_q && !rden_q) begin
      wren_d  = ~cmd_rd_i;
      rden_d  = cmd_rd_i;
      addr_d  = cmd_addr_i;
      wdata_d = cmd_rd_i ? 32'd0 : cmd_wdata_i;
    end
  end

  // Request and address/data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign cmd_done_o   = wr_ok | rd_ok;
  assign cmd_rdata_o  = avmm_rdata_i;
  assign avmm_addr_o  = addr_q;
  assign avmm_wdata_o = wdata_q;
  assign avmm_wren_o  = wren_q;
  assign avmm_rden_o  = rden_q;

endmodule

// File: rtl/axist_bringup_seq.sv
// Autonomous AXI-ST-over-AIB bring-up and self-test sequencer.
// Drives the management bus through the AVMM master sub-block.
module axist_bringup_seq
  import axist_bringup_pkg::*;
#(
  parameter logic [31:0] DELAY_X      = 32'd12,
  parameter logic [31:0] DELAY_Y      = 32'd32,
  parameter logic [31:0] DELAY_Z      = 32'd6000,
  parameter logic [31:0] PKT_CTRL     = 32'h0000_0FF5,
  parameter int          AXI_RST_HOLD = 101,
  parameter int          POLL_GAP     = 30,
  parameter logic [15:0] POLL_LIMIT   = 16'd4095
) (
  input  logic        mgmt_clk,
  input  logic        i_mgmt_rst,
  input  logic        i_start,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic [31:0] i_readdata,
  input  logic        i_readdatavalid,
  input  logic        i_waitreq,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [1:0]  o_result,
  output logic [63:0] o_dout_first,
  output logic [63:0] o_din_first,
  output logic [63:0] o_dout_last,
  output logic [63:0] o_din_last
);

  localparam logic [15:0] GAP_LOAD  = 16'(POLL_GAP);
  localparam logic [15:0] HOLD_LAST = 16'(AXI_RST_HOLD - 1);
  localparam logic [15:0] POLL_LAST = POLL_LIMIT - 16'd1;

  state_e           state_q, state_d;
  logic [15:0]      poll_q, poll_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      hold_q, hold_d;
  logic [2:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  result_e          res_q, res_d;
  logic [3:0][63:0] cap_q, cap_d;
  result_e          grade_res;

  logic        cmd_valid;
  logic        cmd_rd;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_done;
  logic [31:0] cmd_rdata;

  axist_avmm_mst_if u_mst (
    .clk_i          (mgmt_clk),
    .rst_i          (i_mgmt_rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_rd_i       (cmd_rd),
    .cmd_addr_i     (cmd_addr),
    .cmd_wdata_i    (cmd_wdata),
    .cmd_done_o     (cmd_done),
    .cmd_rdata_o    (cmd_rdata),
    .avmm_addr_o    (o_wr_addr),
    .avmm_wdata_o   (o_wrdata),
    .avmm_wren_o    (o_wren),
    .avmm_rden_o    (o_rden),
    .avmm_rdata_i   (i_readdata),
    .avmm_rdvalid_i (i_readdatavalid),
    .avmm_waitreq_i (i_waitreq)
  );

  assign grade_res = grade({cmd_rdata[3], cmd_rdata[1:0]});

  // Sequencer: one bus transaction per state, advance on its completion.
  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    res_d     = res_q;
    cap_d     = cap_q;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_CFG_X;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          res_d   = RES_PASS;
          cap_d   = '0;
        end
      end
      S_CFG_X: begin
        cmd_valid = 1'b1;
        cmd_addr  = DELAY_X_ADDR;
        cmd_wdata = DELAY_X;
        if (cmd_done)
          state_d = S_CFG_Y;
      end
      S_CFG_Y: begin
        cmd_valid = 1'b1;
        cmd_addr  = DELAY_Y_ADDR;
        cmd_wdata = DELAY_Y;
        if (cmd_done)
          state_d = S_CFG_Z;
      end
      S_CFG_Z: begin
        cmd_valid = 1'b1;
        cmd_addr  = DELAY_Z_ADDR;
        cmd_wdata = DELAY_Z;
        if (cmd_done)
          state_d = S_RST_ON;
      end
      S_RST_ON: begin
        cmd_valid = 1'b1;
        cmd_addr  = AXI_CTRL;
        cmd_wdata = 32'd1;
        if (cmd_done) begin
          state_d = S_RST_WAIT;
          hold_d  = 16'd0;
        end
      end
      S_RST_WAIT: begin
        if (hold_q == HOLD_LAST)
          state_d = S_RST_OFF;
        else
          hold_d = hold_q + 16'd1;
      end
      S_RST_OFF: begin
        cmd_valid = 1'b1;
        cmd_addr  = AXI_CTRL;
        cmd_wdata = 32'd0;
        if (cmd_done) begin
          state_d = S_LINK_POLL;
          poll_d  = 16'd0;
          gap_d   = 16'd0;
        end
      end
      S_LINK_POLL: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else begin
          cmd_valid = 1'b1;
          cmd_rd    = 1'b1;
          cmd_addr  = LINKUP_STS;
          if (cmd_done) begin
            if (cmd_rdata[3:0] == 4'hF) begin
              state_d = S_PKT_GO;
            end else if (poll_q == POLL_LAST) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b0;
              res_d   = RES_TIMEOUT;
            end else begin
              poll_d = poll_q + 16'd1;
              gap_d  = GAP_LOAD;
            end
          end
        end
      end
      S_PKT_GO: begin
        cmd_valid = 1'b1;
        cmd_addr  = TX_PKT_CTRL;
        cmd_wdata = PKT_CTRL;
        if (cmd_done) begin
          state_d = S_CKR_POLL;
          poll_d  = 16'd0;
          gap_d   = 16'd0;
        end
      end
      S_CKR_POLL: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else begin
          cmd_valid = 1'b1;
          cmd_rd    = 1'b1;
          cmd_addr  = RX_CKR_STS;
          if (cmd_done) begin
            if (cmd_rdata[1]) begin
              state_d = S_CAPTURE;
              idx_d   = 3'd0;
            end else if (poll_q == POLL_LAST) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b0;
              res_d   = RES_TIMEOUT;
            end else begin
              poll_d = poll_q + 16'd1;
              gap_d  = GAP_LOAD;
            end
          end
        end
      end
      S_CAPTURE: begin
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        cmd_addr  = cap_addr(idx_q);
        if (cmd_done) begin
          if (idx_q[0])
            cap_d[idx_q[2:1]][63:32] = cmd_rdata;
          else
            cap_d[idx_q[2:1]][31:0] = cmd_rdata;
          if (idx_q == 3'd7)
            state_d = S_GRADE;
          else
            idx_d = idx_q + 3'd1;
        end
      end
      S_GRADE: begin
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        cmd_addr  = RX_CKR_STS;
        if (cmd_done) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = grade_res;
          pass_d  = (grade_res == RES_PASS);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, counters, status and capture registers.
  always_ff @(posedge mgmt_clk) begin
    if (i_mgmt_rst) begin
      state_q <= S_IDLE;
      poll_q  <= 16'd0;
      gap_q   <= 16'd0;
      hold_q  <= 16'd0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      res_q   <= RES_PASS;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      res_q   <= res_d;
      cap_q   <= cap_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_result     = res_q;
  assign o_dout_first = cap_q[0];
  assign o_din_first  = cap_q[1];
  assign o_dout_last  = cap_q[2];
  assign o_din_last   = cap_q[3];

endmodule

// File: tb/tb_axist_bringup_seq.sv
// Bench for axist_bringup_seq: scripted AVMM slave plus
// an expected-transaction list built from the sequence rules.
module tb_axist_bringup_seq;

  localparam int PL = 8;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] wr_addr;
  logic [31:0] wrdata;
  logic        wren;
  logic        rden;
  logic [31:0] rdata;
  logic        rdvalid;
  logic        waitreq;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  result;
  logic [63:0] dout_first;
  logic [63:0] din_first;
  logic [63:0] dout_last;
  logic [63:0] din_last;

  int checks = 0;
  int failures = 0;

  txn_t        exp_q[$];
  logic [31:0] link_rsp[$];
  logic [31:0] ckr_rsp[$];
  logic [31:0] grade_v;
  logic [31:0] cap_w[8];
  logic [1:0]  exp_res;
  logic        exp_pass;
  logic [63:0] exp_cap[4];

  bit          stall_fixed = 0;
  int          stall_max = 0;
  int          link_reads = 0;
  bit          first_pend = 0;
  logic [31:0] first_addr = 32'd0;

  always #5 clk = ~clk;

  axist_bringup_seq #(.POLL_LIMIT(16'(PL))) dut (
    .mgmt_clk        (clk),
    .i_mgmt_rst      (rst),
    .i_start         (start),
    .o_wr_addr       (wr_addr),
    .o_wrdata        (wrdata),
    .o_wren          (wren),
    .o_rden          (rden),
    .i_readdata      (rdata),
    .i_readdatavalid (rdvalid),
    .i_waitreq       (waitreq),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_result        (result),
    .o_dout_first    (dout_first),
    .o_din_first     (din_first),
    .o_dout_last     (dout_last),
    .o_din_last      (din_last)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic push(input bit rd, input logic [31:0] a,
                      input logic [31:0] d);
    txn_t t;
    t.rd = rd;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  // Expected bus traffic and final outputs from the sequence rules.
  task automatic build();
    bit stop;
    bit to;
    logic [31:0] g;
    logic [31:0] caddr[8];
    caddr = '{32'h5000_4000, 32'h5000_4004, 32'h5000_4200, 32'h5000_4204,
              32'h5000_4100, 32'h5000_4104, 32'h5000_4300, 32'h5000_4304};
    exp_q.delete();
    to = 0;
    push(0, 32'h5000_2000, 32'd12);
    push(0, 32'h5000_2004, 32'd32);
    push(0, 32'h5000_2008, 32'd6000);
    push(0, 32'h5000_3000, 32'd1);
    push(0, 32'h5000_3000, 32'd0);
    stop = 0;
    for (int i = 0; i < link_rsp.size() && !stop; i++) begin
      push(1, 32'h5000_1008, link_rsp[i]);
      if (link_rsp[i][3:0] == 4'hF) stop = 1;
      else if (i + 1 == PL) begin stop = 1; to = 1; end
    end
    if (!to) begin
      push(0, 32'h5000_1000, 32'h0000_0FF5);
      stop = 0;
      for (int i = 0; i < ckr_rsp.size() && !stop; i++) begin
        push(1, 32'h5000_1004, ckr_rsp[i]);
        if (ckr_rsp[i][1]) stop = 1;
        else if (i + 1 == PL) begin stop = 1; to = 1; end
      end
    end
    if (!to) begin
      for (int i = 0; i < 8; i++) push(1, caddr[i], cap_w[i]);
      push(1, 32'h5000_1004, grade_v);
    end
    if (to) begin
      exp_res = 2'd3;
      for (int k = 0; k < 4; k++) exp_cap[k] = 64'd0;
    end else begin
      g = grade_v;
      if (g[3] && g[1] && g[0]) exp_res = 2'd0;
      else if (!g[3]) exp_res = 2'd2;
      else exp_res = 2'd1;
      for (int k = 0; k < 4; k++)
        exp_cap[k] = {cap_w[2*k+1], cap_w[2*k]};
    end
    exp_pass = (exp_res == 2'd0);
  endtask

  task automatic set_base();
    link_rsp.delete();
    ckr_rsp.delete();
    link_rsp.push_back(32'hF);
    ckr_rsp.push_back(32'hB);
    grade_v = 32'hB;
    for (int i = 0; i < 8; i++)
      cap_w[i] = i[0] ? 32'h2222_2222 : 32'h1111_1111;
  endtask

  task automatic set_rand();
    int n;
    logic [31:0] v;
    link_rsp.delete();
    ckr_rsp.delete();
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      v[3:0] = 4'($urandom_range(0, 14));
      link_rsp.push_back(v);
    end
    v = $urandom;
    v[3:0] = 4'hF;
    link_rsp.push_back(v);
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      v[1] = 1'b0;
      ckr_rsp.push_back(v);
    end
    v = $urandom;
    v[1] = 1'b1;
    ckr_rsp.push_back(v);
    grade_v = $urandom;
    for (int i = 0; i < 8; i++) cap_w[i] = $urandom;
    stall_max = $urandom_range(0, 3);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_seq(input bit mid_start);
    int n;
    build();
    link_reads = 0;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_cleared", 64'(done), 64'd0);
    n = 0;
    while (!done && n < 20000) begin
      if (mid_start && n == 40) start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout got=%0d want=<20000 cycles", n);
    end
    chk("result", 64'(result), 64'(exp_res));
    chk("pass", 64'(pass), 64'(exp_pass));
    chk("dout_first", dout_first, exp_cap[0]);
    chk("din_first", din_first, exp_cap[1]);
    chk("dout_last", dout_last, exp_cap[2]);
    chk("din_last", din_last, exp_cap[3]);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("txn_left", 64'(exp_q.size()), 64'd0);
  endtask

  // AVMM slave and per-cycle bus checker.
  initial begin
    txn_t t;
    int cyc;
    bit in_x;
    bit have_prev;
    int stall;
    int st_init;
    int hold;
    int prev_cyc;
    logic [31:0] prev_addr;
    logic [31:0] x_addr;
    logic [31:0] x_wd;
    cyc = 0;
    in_x = 0;
    have_prev = 0;
    stall = 0;
    st_init = 0;
    hold = 0;
    prev_cyc = 0;
    prev_addr = 32'd0;
    x_addr = 32'd0;
    x_wd = 32'd0;
    waitreq = 1'b0;
    rdvalid = 1'b0;
    rdata = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_x = 0;
        have_prev = 0;
        waitreq = 1'b0;
        rdvalid = 1'b0;
        first_pend = 1;
      end else if (wren || rden) begin
        chk("one_request", 64'(wren & rden), 64'd0);
        if (!in_x) begin
          in_x = 1;
          hold = 0;
          st_init = stall_fixed ? 5 : $urandom_range(0, stall_max);
          stall = st_init;
          x_addr = wr_addr;
          x_wd = wrdata;
          if (have_prev && prev_addr == wr_addr) begin
            if (wr_addr == 32'h5000_3000)
              chk("axi_rst_hold", 64'(cyc - prev_cyc >= 101), 64'd1);
            else
              chk("poll_gap", 64'(cyc - prev_cyc - 1 >= 30), 64'd1);
          end
        end else begin
          chk("req_stable", {wr_addr, wrdata}, {x_addr, x_wd});
        end
        hold++;
        rdata = $urandom;
        if (stall > 0) begin
          stall--;
          if (!stall_fixed && rden && $urandom_range(0, 1) == 1) begin
            waitreq = 1'b0;
            rdvalid = 1'b0;
          end else begin
            waitreq = 1'b1;
            rdvalid = 1'($urandom_range(0, 1));
          end
        end else begin
          waitreq = 1'b0;
          rdvalid = rden;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_txn got=%h want=none", wr_addr);
          end else begin
            t = exp_q.pop_front();
            if (t.rd) rdata = t.data;
            chk("txn_kind", 64'(rden), 64'(t.rd));
            chk("txn_addr", 64'(wr_addr), 64'(t.addr));
            if (!t.rd) chk("txn_wdata", 64'(wrdata), 64'(t.data));
            chk("req_hold", 64'(hold), 64'(st_init + 1));
          end
          if (rden && wr_addr == 32'h5000_1008) link_reads++;
          if (first_pend) begin
            first_addr = wr_addr;
            first_pend = 0;
          end
          in_x = 0;
          have_prev = 1;
          prev_addr = wr_addr;
          prev_cyc = cyc;
        end
      end else begin
        waitreq = 1'($urandom_range(0, 1));
        rdvalid = ($urandom_range(0, 3) == 0);
        rdata = $urandom;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_rden", 64'(rden), 64'd0);
    chk("rst_addr_data", {wr_addr, wrdata}, 64'd0);
    chk("rst_status", {60'd0, busy, done, result}, 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_caps", dout_first | din_first | dout_last | din_last, 64'd0);
    start = 1'b0;
    rst = 1'b0;

    set_base();
    run_seq(0);
    chk("pin_dout_first", dout_first, 64'h2222_2222_1111_1111);
    chk("pin_pass", {62'd0, result, pass}, 64'd1);

    stall_fixed = 1;
    set_base();
    run_seq(0);
    stall_fixed = 0;
    chk("pin_stall_result", 64'(result), 64'd0);

    set_base();
    link_rsp.delete();
    link_rsp = '{32'h7, 32'h7, 32'h7, 32'hF};
    stall_max = 2;
    run_seq(1);
    chk("pin_link_reads", 64'(link_reads), 64'd4);

    set_base();
    grade_v = 32'h3;
    run_seq(0);
    chk("pin_align", {62'd0, result, pass}, 64'h4);

    set_base();
    grade_v = 32'hA;
    run_seq(0);
    chk("pin_data_fail", {62'd0, result, pass}, 64'h2);

    set_base();
    link_rsp.delete();
    for (int i = 0; i < 10; i++) link_rsp.push_back(32'h7);
    run_seq(0);
    chk("pin_timeout", 64'(result), 64'd3);
    chk("pin_timeout_reads", 64'(link_reads), 64'd8);

    stall_fixed = 1;
    set_base();
    build();
    pulse_start();
    n = 0;
    while (!(wren && wr_addr == 32'h5000_2004) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("mid_cfg_y_seen", 64'(n < 200), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_wren", 64'(wren), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    start = 1'b0;
    rst = 1'b0;
    stall_fixed = 0;
    set_rand();
    run_seq(0);
    chk("restart_addr", 64'(first_addr), 64'h5000_2000);

    for (int r = 0; r < 5; r++) begin
      set_rand();
      run_seq(r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
